// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the MIPS architectural register file.
//   DATA_W / ADDR_W : register width and register address width
//   NUM_REGS        : depth of the file (2**ADDR_W)
//   ZERO_REG        : hardwired-zero register index
//   reg_addr_t, reg_data_t, reg_array_t : address, data and storage views
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Packed so the whole storage can be handed to each read port as one value.
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // A write only takes effect (and only bypasses) when enabled, out of reset
  // and aimed at a register other than the hardwired zero.
  function automatic logic write_active(input logic      rst,
                                        input logic      wen,
                                        input reg_addr_t waddr);
    return wen && !rst && (waddr != ZERO_REG);
  endfunction

endpackage : regfile_pkg

// File: rtl/register_file_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   One combinational read port of the register file, with write-through
//   bypass so a same-cycle writeback is visible to decode.
//   Ports:
//     rst        : asynchronous reset, forces the output to 0
//     addr       : register address to read
//     regs       : view of the stored register contents
//     writeEn    : write port enable
//     writeAddr  : write port address
//     writeData  : write port data (bypass source)
//     dataout    : read result
// ---------------------------------------------------------------------------
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic       rst,
  input  reg_addr_t  addr,
  input  reg_array_t regs,
  input  logic       writeEn,
  input  reg_addr_t  writeAddr,
  input  reg_data_t  writeData,
  output reg_data_t  dataout
);

  logic bypass;

  // write_active already excludes writes to the zero register, so a read of
  // address 0 can never pick up writeData.
  assign bypass = write_active(rst, writeEn, writeAddr) && (writeAddr == addr);

  always_comb begin
    dataout = '0;
    if (rst) begin
      dataout = '0;
    end else if (addr == ZERO_REG) begin
      dataout = '0;
    end else if (bypass) begin
      dataout = writeData;
    end else begin
      dataout = regs[addr];
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   32 x 32-bit MIPS general-purpose register file: two combinational read
//   ports (rs/rt) with write-through bypass and one clocked write port.
//   Register 0 always reads zero and is never written.
//   Ports:
//     clk        : rising-edge clock for the write port
//     rst        : asynchronous active-high reset, clears all registers
//     addr1      : read port 1 address (rs)
//     addr2      : read port 2 address (rt)
//     writeAddr  : write port address (rd/rt)
//     writeData  : write data
//     writeEn    : write enable, sampled on the rising edge of clk
//     dataout1   : contents of register addr1
//     dataout2   : contents of register addr2
// ---------------------------------------------------------------------------
module register_file
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEn,
  output logic [DATA_W-1:0] dataout1,
  output logic [DATA_W-1:0] dataout2
);

  reg_array_t regs_q;
  reg_array_t regs_d;

  // Next-state: only the addressed entry changes; entry 0 is never touched,
  // so it keeps the zero it received at reset.
  always_comb begin
    regs_d = regs_q;
    if (write_active(1'b0, writeEn, writeAddr)) begin
      regs_d[writeAddr] = writeData;
    end
  end

  // Reset dominates any write presented in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port u_rd1 (
    .rst       (rst),
    .addr      (addr1),
    .regs      (regs_q),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .dataout   (dataout1)
  );

  regfile_read_port u_rd2 (
    .rst       (rst),
    .addr      (addr2),
    .regs      (regs_q),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .dataout   (dataout2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  addr1;
  logic [4:0]  addr2;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        writeEn;
  logic [31:0] dataout1;
  logic [31:0] dataout2;

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .addr1     (addr1),
    .addr2     (addr2),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .writeEn   (writeEn),
    .dataout1  (dataout1),
    .dataout2  (dataout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   vectors  = 0;
  int   miscomp  = 0;
  bit   stim_done = 0;

  // Monitor: whenever the stimulus says the outputs are ready, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (dataout1 !== e.exp1 || dataout2 !== e.exp2) begin
          miscomp++;
          $display("FAIL %s: got dataout1=%h dataout2=%h, want dataout1=%h dataout2=%h",
                   e.name, dataout1, dataout2, e.exp1, e.exp2);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    sb_q.push_back(e);
    -> sample_ev;
    #2;
  endtask

  task automatic set_in(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; writeEn = we; writeAddr = wa; writeData = wd; addr1 = a1; addr2 = a2;
  endtask

  initial begin
    int unsigned guard;
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    @(negedge clk); #1;
    expect_out("reset_a0_a1", 32'h0, 32'h0);
    // Bypass must be suppressed while in reset.
    set_in(1'b1, 1'b1, 5'd5, 32'h1111_2222, 5'd5, 5'd5); #1;
    expect_out("reset_no_bypass", 32'h0, 32'h0);

    // Release reset, read all 32 addresses.
    @(negedge clk);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      addr1 = 5'(i); addr2 = 5'(31 - i); #1;
      expect_out($sformatf("post_reset_read_%0d", i), 32'h0, 32'h0);
    end

    // Plain write 14 <= 7.
    @(negedge clk);
    set_in(1'b0, 1'b1, 5'd14, 32'd7, 5'd1, 5'd2);
    @(negedge clk);
    set_in(1'b0, 1'b0, 5'd14, 32'd7, 5'd14, 5'd1); #1;
    expect_out("write14_read", 32'd7, 32'd0);

    // Bypass on both ports, then stored value after the edge.
    set_in(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5); #1;
    expect_out("bypass_both", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    addr2 = 5'd14; #1;
    expect_out("bypass_one_port", 32'hDEAD_BEEF, 32'd7);
    @(negedge clk);
    set_in(1'b0, 1'b0, 5'd5, 32'h0, 5'd5, 5'd5); #1;
    expect_out("bypass_stored", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Zero register: no bypass, no write.
    set_in(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0); #1;
    expect_out("zero_no_bypass", 32'h0, 32'h0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5); #1;
    expect_out("zero_after_write", 32'h0, 32'hDEAD_BEEF);

    // writeEn low: no bypass and no state change.
    set_in(1'b0, 1'b0, 5'd3, 32'd9, 5'd3, 5'd3); #1;
    expect_out("wen_low_no_bypass", 32'h0, 32'h0);
    @(negedge clk); #1;
    expect_out("wen_low_no_write", 32'h0, 32'h0);

    // Top-of-file entry and overwrite.
    set_in(1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5, 5'd14, 5'd2);
    @(negedge clk);
    set_in(1'b0, 1'b1, 5'd14, 32'h1234_5678, 5'd31, 5'd14); #1;
    expect_out("reg31_and_bypass14", 32'hA5A5_A5A5, 32'h1234_5678);
    @(negedge clk);
    set_in(1'b0, 1'b1, 5'd14, 32'd7, 5'd14, 5'd31);
    @(negedge clk);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 5'd31); #1;
    expect_out("rewrite14", 32'd7, 32'hA5A5_A5A5);

    // Asynchronous reset between edges, with a write attempted during reset.
    rst = 1'b1; #1;
    expect_out("async_reset_clears", 32'h0, 32'h0);
    writeEn = 1'b1; writeAddr = 5'd14; writeData = 32'h55; addr2 = 5'd14; #1;
    expect_out("reset_write_blocked_bypass", 32'h0, 32'h0);
    @(negedge clk);
    // First edge after release accepts a write.
    set_in(1'b0, 1'b1, 5'd7, 32'd77, 5'd14, 5'd5); #1;
    expect_out("after_reset_cleared", 32'h0, 32'h0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31); #1;
    expect_out("first_write_after_reset", 32'd77, 32'h0);

    @(negedge clk);
    guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      miscomp++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    stim_done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL watchdog: simulation time expired, want completion");
      $fatal(1);
    end
  end

endmodule : tb_register_file
